store_buffer: RTL and testbench
===============================

# store_buffer

Store-side counterpart of the immediate/load extender. It accepts narrow stores from the MEM stage: byte, halfword or word data in the low bits of a 32-bit register value. It aligns each store into word lanes with byte enables, and queues it in a small FIFO. It then issues each entry to data memory over a request/grant handshake, so the pipeline does not stall on memory write latency.

## Interface
Parameters:
- DEPTH, 4: number of FIFO entries; power of two, 2 to 16.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst_n  input  1  Reset, asynchronous and active-low.
- st_valid  input  1  MEM stage presents a store.
- st_ready  output  1  Buffer can accept a store this cycle.
- st_addr  input  32  Byte address of the store.
- st_data  input  32  Register data; only the low bits covered by st_size are meaningful.
- st_size  input  2  Store size: 00 byte, 01 half, 10 word, 11 illegal.
- st_err  output  1  One-cycle pulse reporting a misaligned or illegal store.
- mem_req  output  1  Head entry valid and offered to memory.
- mem_gnt  input  1  Memory accepts the head entry this cycle.
- mem_addr  output  32  Word address of the head entry; bits [1:0] are always 0.
- mem_wdata  output  32  Lane-aligned write data of the head entry.
- mem_be  output  4  Byte enables of the head entry.
- sb_empty  output  1  No entries held; used by the hazard unit to order loads behind stores.

## Operation
- A store is accepted when st_valid and st_ready are both high; st_ready = not full.
- Formatting is performed on accept:
  - Byte: wdata = {4{st_data[7:0]}}; be = 0001 shifted left by st_addr[1:0].
  - Half: wdata = {2{st_data[15:0]}}; be = 0011 when st_addr[1]=0, 1100 when st_addr[1]=1.
  - Word: wdata = st_data; be = 1111.
- Legality is checked on accept:
  - Misaligned: half with st_addr[0]=1, or word with st_addr[1:0]≠00.
  - Illegal size: st_size = 11.
  - Either case raises st_err on the next cycle, and the store is not enqueued.
  - st_ready is unaffected by an error.
- The FIFO uses a head pointer, a tail pointer and a count of log2(DEPTH)+1 bits. Both pointers wrap modulo DEPTH.
- mem_req is high whenever count ≠ 0. mem_addr, mem_wdata and mem_be come straight from the head registers and are stable while mem_req is high and mem_gnt is low.
- The head is popped on the edge where mem_req and mem_gnt are both high.
- A push and a pop in the same cycle are both performed and count is unchanged. When full, a simultaneous pop does not open st_ready in that cycle, because st_ready depends only on the registered count.
- When empty, mem_gnt is ignored.
- Entries issue to memory strictly in accept order.

## Timing
- Reset values: st_ready=1, st_err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, sb_empty=1. Pointers and count are 0.
- Reset asserted mid-operation discards all queued entries immediately, asynchronously. No memory write completes after reset assertion.
- Latency: a store accepted in cycle N appears with mem_req=1 in cycle N+1 if the buffer was empty. A grant in cycle N+1 retires it, and sb_empty=1 in cycle N+2.
- st_err is registered and asserted exactly one cycle after the offending accept.
- Throughput is one accept and one retire per cycle sustained.

## Configuration
- STORE_MERGE_EN defined:
  - An accepted legal store whose word address equals the tail entry's word address is merged into the tail entry instead of being pushed.
  - Merging happens only when count ≥ 2, so the tail entry is never the head being offered.
  - Merge rule: for each lane with the new be bit set, the new byte replaces the old byte; the tail's be becomes the OR of old and new.
  - Count is unchanged by a merge. If a pop happens in the same cycle, count decrements.
  - A merge is accepted even when the buffer is full.
  - st_ready = not full, or count ≥ 2 and the tail matches st_addr[31:2].
- STORE_MERGE_EN undefined:
  - Every legal store occupies its own entry.
  - No address comparator is built.

## Structure
- Shared package store_pkg holds:
  - Size encoding constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The entry struct: word address [31:2], wdata, be.
- Sub-module store_lane_fmt is purely combinational. It maps addr[1:0], size and data to wdata, be and an err flag; the top level instantiates it once on the input path.
- All state lives in store_buffer.

## Test plan
- Byte store at 0x1003 with data 0x000000A5, then grant → mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_be=1000; sb_empty returns to 1 two cycles after accept.
- Half store at 0x2001 with size 01 → st_err pulses one cycle later; no mem_req; sb_empty stays 1.
- Hold mem_gnt=0 and push 4 word stores (DEPTH=4) → st_ready=0 after the fourth; a fifth store is held off. Release grant → entries retire in order, and st_ready rises the cycle after the first pop.
- With the buffer full, assert push and grant in the same cycle → the push is not taken (st_ready=0). Next cycle, push and pop together → count stays 3.
- STORE_MERGE_EN: hold grant low; store word 0x11223344 at 0x3000, byte 0xEE at 0x4000, then byte 0xFF at 0x4002 → the second entry becomes wdata 0x00FF00EE (unwritten lanes don't-care), be=0101, count=2.
- Assert rst_n low with 3 entries queued and mem_req high → mem_req=0 and sb_empty=1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: shared definitions for the store buffer.
// Holds the store-size encoding and the layout of one queued store entry.
package store_pkg;

    // Store size encoding presented by the MEM stage (2'b11 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // One buffered store: word address, lane-aligned data and byte enables
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: combinational store formatter.
// Replicates narrow store data across the word lanes, derives the byte
// enables from the low address bits and flags misaligned or illegal sizes.
module store_lane_fmt
    import store_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        err_o
);

    // Lane placement and legality for each store size
    always_comb begin
        wdata_o = '0;
        be_o    = '0;
        err_o   = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
            end
            SZ_HALF: begin
                wdata_o = {2{data_i[15:0]}};
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                err_o   = addr_lo_i[0];
            end
            SZ_WORD: begin
                wdata_o = data_i;
                be_o    = 4'b1111;
                err_o   = |addr_lo_i;
            end
            default: begin
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: formats MEM-stage stores into word lanes and queues them in a
// small FIFO that drains to data memory over a req/gnt handshake.
// Optional feature macro: STORE_MERGE_EN -- a legal store hitting the tail
// entry's word (with at least two entries held) is merged into that entry.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        sb_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    sb_entry_t       entries_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            st_err_q;

    logic [31:0]     fmt_wdata;
    logic [3:0]      fmt_be;
    logic            fmt_err;

    logic            full;
    logic            accept;
    logic            legal_acc;
    logic            push;
    logic            pop;
    sb_entry_t       new_entry;

    store_lane_fmt u_fmt (
        .addr_lo_i (st_addr[1:0]),
        .size_i    (st_size),
        .data_i    (st_data),
        .wdata_o   (fmt_wdata),
        .be_o      (fmt_be),
        .err_o     (fmt_err)
    );

    assign full      = (count_q == CW'(DEPTH));
    assign accept    = st_valid && st_ready;
    assign legal_acc = accept && !fmt_err;
    // A grant while empty is ignored
    assign pop       = (count_q != '0) && mem_gnt;

    assign new_entry.waddr = st_addr[31:2];
    assign new_entry.wdata = fmt_wdata;
    assign new_entry.be    = fmt_be;

`ifdef STORE_MERGE_EN
    logic [PW-1:0]   tail_prev;
    logic            merge_hit;
    logic            do_merge;
    sb_entry_t       merged_entry;

    // Tail entry sits one slot behind the write pointer
    assign tail_prev = tail_q - 1'b1;

    // Merge only when the tail is not the head currently offered to memory
    always_comb begin
        merge_hit = (count_q >= CW'(2)) &&
                    (entries_q[tail_prev].waddr == st_addr[31:2]);
        st_ready  = !full || merge_hit;
        do_merge  = legal_acc && merge_hit;
        push      = legal_acc && !merge_hit;
    end

    // New bytes overwrite their lanes; untouched lanes keep the old data
    always_comb begin
        merged_entry       = entries_q[tail_prev];
        merged_entry.be    = entries_q[tail_prev].be | fmt_be;
        for (int b = 0; b < 4; b++) begin
            if (fmt_be[b]) begin
                merged_entry.wdata[8*b +: 8] = fmt_wdata[8*b +: 8];
            end
        end
    end
`else
    // Every legal store takes its own slot; readiness is just "not full"
    always_comb begin
        st_ready = !full;
        push     = legal_acc;
    end
`endif

    // Pointer and occupancy next-state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state, entry storage and the registered error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            st_err_q <= accept && fmt_err;
            if (push) begin
                entries_q[tail_q] <= new_entry;
            end
`ifdef STORE_MERGE_EN
            if (do_merge) begin
                entries_q[tail_prev] <= merged_entry;
            end
`endif
        end
    end

    assign st_err    = st_err_q;
    assign mem_req   = (count_q != '0);
    assign sb_empty  = (count_q == '0);
    assign mem_addr  = {entries_q[head_q].waddr, 2'b00};
    assign mem_wdata = entries_q[head_q].wdata;
    assign mem_be    = entries_q[head_q].be;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench with a scoreboard of expected memory writes.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        sb_empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .sb_empty  (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference formatting, written as explicit tables
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output logic ok, output logic [31:0] w, output logic [3:0] be);
        ok = 1'b0; w = '0; be = '0;
        case (s)
            2'd0: begin
                ok = 1'b1;
                w  = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (a[1:0])
                    2'd0: be = 4'b0001;
                    2'd1: be = 4'b0010;
                    2'd2: be = 4'b0100;
                    default: be = 4'b1000;
                endcase
            end
            2'd1: begin
                ok = (a[0] == 1'b0);
                w  = {d[15:0], d[15:0]};
                be = a[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                ok = (a[1:0] == 2'b00);
                w  = d;
                be = 4'b1111;
            end
            default: ok = 1'b0;
        endcase
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Present a store, check readiness against the model, record expectation
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        logic        ok, hit;
        logic [31:0] w;
        logic [3:0]  be;
        exp_t        e;
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
        #1;
        model(a, d, s, ok, w, be);
        hit = 1'b0;
`ifdef STORE_MERGE_EN
        if (sb.size() >= 2 && sb[sb.size()-1].addr[31:2] == a[31:2]) hit = 1'b1;
`endif
        check("st_ready", {31'b0, st_ready}, {31'b0, (sb.size() < DEPTH) || hit});
        if (st_ready && ok) begin
            if (hit) begin
                e = sb[sb.size()-1];
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) e.wdata[8*b +: 8] = w[8*b +: 8];
                end
                e.be   = e.be | be;
                e.mask = be_mask(e.be);
                sb[sb.size()-1] = e;
            end else begin
                e.addr = {a[31:2], 2'b00}; e.wdata = w; e.be = be; e.mask = 32'hFFFF_FFFF;
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        mem_gnt = 1'b1;
        for (int i = 0; i < 20 && !sb_empty; i++) tick();
        mem_gnt = 1'b0;
        check("drain_empty", {31'b0, sb_empty}, 32'd1);
        check("drain_sb_size", sb.size(), 32'd0);
    endtask

    // Retirement monitor: every granted head must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mem_req && mem_gnt) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL retire_unexpected observed=%h expected=none", mem_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata & e.mask, e.wdata & e.mask);
                check("mem_be", {28'b0, mem_be}, {28'b0, e.be});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_gnt = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_st_ready", {31'b0, st_ready}, 32'd1);
        check("rst_st_err", {31'b0, st_err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Byte store at 0x1003, granted in the following cycle
        drive_store(32'h0000_1003, 32'h0000_00A5, 2'b00);
        tick();
        st_valid = 1'b0;
        check("lat_mem_req", {31'b0, mem_req}, 32'd1);
        check("lat_sb_empty0", {31'b0, sb_empty}, 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("lat_sb_empty1", {31'b0, sb_empty}, 32'd1);

        // Misaligned half and illegal size
        drive_store(32'h0000_2001, 32'h0000_1234, 2'b01);
        tick();
        st_valid = 1'b0;
        check("mis_st_err", {31'b0, st_err}, 32'd1);
        check("mis_mem_req", {31'b0, mem_req}, 32'd0);
        check("mis_sb_empty", {31'b0, sb_empty}, 32'd1);
        tick();
        check("mis_st_err_clr", {31'b0, st_err}, 32'd0);
        drive_store(32'h0000_2000, 32'h0000_5678, 2'b11);
        tick();
        st_valid = 1'b0;
        check("ill_st_err", {31'b0, st_err}, 32'd1);
        check("ill_sb_empty", {31'b0, sb_empty}, 32'd1);
        tick();

        // Back-to-back legal stores of every size/offset with grant held high
        mem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] sz;
            logic [1:0] off;
            sz  = (i < 4) ? 2'b00 : (i < 6) ? 2'b01 : 2'b10;
            off = (i < 4) ? 2'(i) : (i < 6) ? 2'((i - 4) * 2) : 2'b00;
            drive_store(32'h0000_7000 + 32'(i * 16) + 32'(off), $urandom, sz);
            tick();
        end
        st_valid = 1'b0;
        drain();

        // Fill to DEPTH with grant held low
        for (int i = 0; i < DEPTH; i++) begin
            drive_store(32'h0000_5000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 2'b10);
            tick();
        end
        st_valid = 1'b0;
        check("full_st_ready", {31'b0, st_ready}, 32'd0);
        drive_store(32'h0000_5010, 32'hA000_0010, 2'b10);
        tick();
        // Push attempt while full coincides with a pop: only the pop happens
        mem_gnt = 1'b1;
        drive_store(32'h0000_5010, 32'hA000_0010, 2'b10);
        tick();
        check("after_pop_ready", {31'b0, st_ready}, 32'd1);
        // Push and pop together: occupancy stays at three
        drive_store(32'h0000_5014, 32'hA000_0014, 2'b10);
        tick();
        mem_gnt = 1'b0;
        check("pushpop_ready", {31'b0, st_ready}, 32'd1);
        drive_store(32'h0000_5018, 32'hA000_0018, 2'b10);
        tick();
        st_valid = 1'b0;
        check("refill_full", {31'b0, st_ready}, 32'd0);
        drain();

`ifdef STORE_MERGE_EN
        drive_store(32'h0000_3000, 32'h1122_3344, 2'b10);
        tick();
        drive_store(32'h0000_4000, 32'h0000_00EE, 2'b00);
        tick();
        drive_store(32'h0000_4002, 32'h0000_00FF, 2'b00);
        tick();
        drive_store(32'h0000_6000, 32'h0000_0001, 2'b10);
        tick();
        drive_store(32'h0000_6004, 32'h0000_0002, 2'b10);
        tick();
        st_valid = 1'b0;
        check("merge_full", {31'b0, st_ready}, 32'd0);
        drain();
`endif

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h0000_8000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 2'b10);
            tick();
        end
        st_valid = 1'b0;
        check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_req", {31'b0, mem_req}, 32'd0);
        check("arst_sb_empty", {31'b0, sb_empty}, 32'd1);
        check("arst_st_ready", {31'b0, st_ready}, 32'd1);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("final_sb_size", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
